dmem_access_ctrl: RTL and testbench

// Sequences one RV32I load/store from the MEM stage onto the data-memory port.

---
 rtl/dmem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Carries one RV32I load or store from the MEM stage to the data-memory port.
// Store data is lane-aligned and given byte enables. The block waits for the
// memory handshake. Load data is extracted from the returned word and then
// sign- or zero-extended. Misaligned accesses and illegal funct3 values skip
// memory entirely. An access that gets no response is aborted after TIMEOUT
// cycles.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_ready      request handshake (accepted only while idle)
//   req_write, req_funct3    1=store / 0=load, RV32I funct3
//   req_addr, req_wdata      byte address, unaligned rs2 value
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_error   extended load data (0 for stores/errors), error flag
//   mem_read, mem_write      memory strobes (at most one high)
//   mem_address              word address
//   mem_wdata, mem_byte_enable  lane-aligned store data and lane mask
//   mem_resp, mem_rdata      memory completion and read word
module dmem_access_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       op_funct3;
    logic [1:0]       op_lane;
    logic             req_legal;

    // funct3 legality plus natural alignment; byte accesses are always aligned.
    function automatic logic access_ok(input logic wr, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            3'b100:  ok = ~wr;
            3'b101:  ok = ~wr & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rs2);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = rs2 << {a, 3'b000};
            2'b01:   d = rs2 << {a[1], 4'b0000};
            default: d = rs2;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [31:0]        bsh, hsh, r;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        bsh = w >> {a, 3'b000};
        hsh = w >> {a[1], 4'b0000};
        sb  = bsh[7:0];
        sh  = hsh[15:0];
        case (f3)
            3'b000:  r = 32'(sb);
            3'b001:  r = 32'(sh);
            3'b100:  r = 32'(bsh[7:0]);
            3'b101:  r = 32'(hsh[15:0]);
            default: r = w;
        endcase
        return r;
    endfunction

    assign req_legal  = access_ok(req_write, req_funct3, req_addr[1:0]);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = req_legal ? ACCESS : RESP;
            ACCESS:  if (mem_resp || tmo_cnt == TMO_LAST) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch / memory strobe / response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt         <= '0;
            op_funct3       <= '0;
            op_lane         <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            resp_rdata      <= '0;
            resp_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_funct3  <= req_funct3;
                        op_lane    <= req_addr[1:0];
                        tmo_cnt    <= '0;
                        resp_rdata <= '0;
                        resp_error <= ~req_legal;
                        // Rejected requests leave every memory-side output untouched.
                        if (req_legal) begin
                            mem_read        <= ~req_write;
                            mem_write       <= req_write;
                            mem_address     <= {req_addr[31:2], 2'b00};
                            mem_wdata       <= req_write ? store_data(req_funct3, req_addr[1:0], req_wdata) : '0;
                            mem_byte_enable <= req_write ? store_be(req_funct3, req_addr[1:0]) : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_resp) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_error <= 1'b0;
                        resp_rdata <= mem_read ? load_extract(op_funct3, op_lane, mem_rdata) : '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TO = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            end
        end
        if (mem_read && mem_write) chk("strobe_exclusive", 32'd1, 32'd0);
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // A legal access: checks the memory-side view, holds it for wait_cyc cycles,
    // then answers and checks the single response pulse.
    task automatic mem_op(input string nm, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int wait_cyc,
                          input logic [31:0] rd, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd);
        exp_q.push_back('{rdata: exp_rd, err: 1'b0});
        issue(wr, f3, a, wd);
        for (int i = 0; i <= wait_cyc; i++) begin
            @(negedge clk);
            chk({nm, "_rd"}, {31'd0, mem_read}, {31'd0, ~wr});
            chk({nm, "_wr"}, {31'd0, mem_write}, {31'd0, wr});
            chk({nm, "_addr"}, mem_address, exp_addr);
            chk({nm, "_wdata"}, mem_wdata, exp_wd);
            chk({nm, "_be"}, {28'd0, mem_byte_enable}, {28'd0, exp_be});
        end
        mem_resp  = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1 mem_resp = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk({nm, "_strobe_off"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({nm, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({nm, "_resp_single"}, {31'd0, resp_valid}, 32'd0);
        #1;
    endtask

    // A rejected access: no strobe ever, response in the cycle after accept.
    task automatic err_op(input string nm, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a);
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        issue(wr, f3, a, 32'hFFFF_FFFF);
        @(negedge clk);
        chk({nm, "_no_strobe"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        chk({nm, "_no_strobe2"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({nm, "_resp_single"}, {31'd0, resp_valid}, 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_resp = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_be", {28'd0, mem_byte_enable}, 32'd0);
        rst = 1'b0;

        mem_op("sb",  1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 2, 32'h0,
               32'h0000_1000, 32'hAB00_0000, 4'b1000, 32'h0);
        mem_op("lh",  1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 32'h8001_1234,
               32'h0000_2000, 32'h0, 4'b0000, 32'hFFFF_8001);
        mem_op("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'h8001_1234,
               32'h0000_2000, 32'h0, 4'b0000, 32'h0000_8001);
        err_op("sw_misal", 1'b1, 3'b010, 32'h0000_3001);
        err_op("lh_misal", 1'b0, 3'b001, 32'h0000_2001);
        err_op("ld_f3_011", 1'b0, 3'b011, 32'h0000_2000);
        err_op("st_f3_100", 1'b1, 3'b100, 32'h0000_2000);
        mem_op("lb",  1'b0, 3'b000, 32'h0000_5001, 32'h0, 0, 32'h0000_7F00,
               32'h0000_5000, 32'h0, 4'b0000, 32'h0000_007F);
        mem_op("lb_neg", 1'b0, 3'b000, 32'h0000_8002, 32'h0, 0, 32'h00A5_0000,
               32'h0000_8000, 32'h0, 4'b0000, 32'hFFFF_FFA5);
        mem_op("lbu", 1'b0, 3'b100, 32'h0000_8002, 32'h0, 0, 32'h00A5_0000,
               32'h0000_8000, 32'h0, 4'b0000, 32'h0000_00A5);
        mem_op("sh",  1'b1, 3'b001, 32'h0000_6002, 32'h1234_ABCD, 1, 32'h0,
               32'h0000_6000, 32'hABCD_0000, 4'b1100, 32'h0);
        // Back-to-back 0-wait store then load
        mem_op("sw",  1'b1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 0, 32'h0,
               32'h0000_7000, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        mem_op("lw",  1'b0, 3'b010, 32'h0000_7000, 32'h0, 0, 32'hCAFE_F00D,
               32'h0000_7000, 32'h0, 4'b0000, 32'hCAFE_F00D);

        // Timeout: strobe stays up for exactly TO cycles, then an error response.
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        hold = 0;
        @(negedge clk);
        while (mem_read && hold < 3 * TO) begin
            hold++;
            @(negedge clk);
        end
        chk("tmo_hold_cycles", hold, TO);
        chk("tmo_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("tmo_strobe_off", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        chk("tmo_resp_single", {31'd0, resp_valid}, 32'd0);

        // Reset in the middle of an access: strobes drop at once, no response.
        issue(1'b0, 3'b010, 32'h0000_9000, 32'h0);
        @(negedge clk);
        chk("rstmid_strobe_before", {31'd0, mem_read}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 32'h1111_1111;
        @(posedge clk);
        #1 mem_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_idle_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("rstmid_idle_ready", {31'd0, req_ready}, 32'd1);
        end

        // One more load after reset to show the controller is usable again.
        mem_op("post_rst_lw", 1'b0, 3'b010, 32'h0000_A004, 32'h0, 1, 32'h0BAD_F00D,
               32'h0000_A004, 32'h0, 4'b0000, 32'h0BAD_F00D);

        repeat (2) @(negedge clk);
        chk("pending_responses", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
